// File: rtl/int_to_fixed_unpacker.sv
// Streaming unpacker: 32-bit words of packed signed int8 lanes in, one signed Q8.8
// element per cycle out, tagged with its index in the vector and an end-of-vector flag.
// Lane 0 is the least significant byte. Unused lanes of a vector's final word are dropped.
module int_to_fixed_unpacker #(
  parameter int N_ELEMS = 8,
  parameter int LANES   = 4,
  parameter int IDX_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [15:0]        out_fixed,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [IDX_W-1:0]  LAST_ELEM = IDX_W'(N_ELEMS - 1);

  logic [8*LANES-1:0] wbuf;
  logic               wvalid;
  logic [LANE_W-1:0]  lane;
  logic [IDX_W-1:0]   elem;

  logic       load;
  logic       last_lane;
  logic       last_elem;
  logic       consume;
  logic       accept;
  logic [7:0] lane_byte;

  // Handshake decode: the output register loads whenever it is empty or being drained,
  // and the buffer frees up in the same cycle its final element loads.
  always_comb begin
    load      = wvalid && (!out_valid || out_ready);
    last_lane = (lane == LAST_LANE);
    last_elem = (elem == LAST_ELEM);
    consume   = load && (last_lane || last_elem);
    in_ready  = !rst && (!wvalid || consume);
    accept    = in_valid && in_ready;
  end

  // Select the current lane of the buffered word.
  always_comb begin
    lane_byte = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) lane_byte = wbuf[8*i +: 8];
    end
  end

  // Word buffer: refill on accept, otherwise release once its last element has loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf   <= '0;
      wvalid <= 1'b0;
    end else if (accept) begin
      wbuf   <= in_word;
      wvalid <= 1'b1;
    end else if (consume) begin
      wvalid <= 1'b0;
    end
  end

  // Lane pointer and element counter advance only on loads, so a stall freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      elem <= '0;
    end else if (load) begin
      lane <= consume ? '0 : lane + LANE_W'(1);
      elem <= last_elem ? '0 : elem + IDX_W'(1);
    end
  end

  // Output register: int8 to Q8.8 is a plain shift by eight, always exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_fixed <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_fixed <= {lane_byte, 8'h00};
      out_idx   <= elem;
      out_last  <= last_elem;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_to_fixed_unpacker.sv
// Self-checking bench: instance a (N_ELEMS=4) for directed sequences, instance b
// (N_ELEMS=6) for partial final words and the randomized scoreboard run.
module tb_int_to_fixed_unpacker;

  localparam int LANES = 4;
  localparam int NB    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in_word_a = '0;
  logic        in_valid_a = 1'b0;
  logic        in_ready_a;
  logic [15:0] out_fixed_a;
  logic [1:0]  out_idx_a;
  logic        out_last_a;
  logic        out_valid_a;
  logic        out_ready_a = 1'b1;

  logic [31:0] in_word_b = '0;
  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [15:0] out_fixed_b;
  logic [2:0]  out_idx_b;
  logic        out_last_b;
  logic        out_valid_b;
  logic        out_ready_b = 1'b1;

  int_to_fixed_unpacker #(.N_ELEMS(4), .LANES(LANES)) u_dut_a (
    .clk(clk), .rst(rst), .in_word(in_word_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_fixed(out_fixed_a), .out_idx(out_idx_a), .out_last(out_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  int_to_fixed_unpacker #(.N_ELEMS(NB), .LANES(LANES)) u_dut_b (
    .clk(clk), .rst(rst), .in_word(in_word_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_fixed(out_fixed_b), .out_idx(out_idx_b), .out_last(out_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a word on port a and hold it until the edge that accepts it.
  task automatic accept_a(input logic [31:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_word_a  = w;
    in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_wait", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  // Same for port b, but leaves in_valid high so words can follow back to back.
  task automatic wait_ready_b();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_wait", 32'(in_ready_b), 32'd1);
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_b2b_accept_wait", 32'(in_ready_a), 32'd1);
  endtask

  // Reference model: vector position advances per element; a word supplies as many
  // lanes as remain in the current vector, at most LANES.
  typedef struct packed {
    logic [15:0] f;
    logic [2:0]  i;
    logic        l;
  } exp_t;

  exp_t mq[$];
  int   mpos = 0;

  task automatic model_push(input logic [31:0] w);
    int   n;
    int   v;
    exp_t e;
    n = LANES;
    if (NB - mpos < n) n = NB - mpos;
    for (int l = 0; l < n; l++) begin
      v = $signed(w[8*l +: 8]) * 256;
      e.f = 16'(v);
      e.i = 3'(mpos);
      e.l = (mpos == NB - 1);
      mq.push_back(e);
      mpos = (mpos + 1) % NB;
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [63:0] exp_fixed;  // element k in bits [16k+15:16k]
  } vec_t;

  vec_t tbl[5];

  logic [15:0] got_f[$];
  logic [2:0]  got_i[$];
  logic        got_l[$];
  logic        got_v[$];
  logic        got_r[$];
  logic [31:0] pw[3];
  logic [15:0] pexp_f[10];
  logic [2:0]  pexp_i[10];

  initial begin
    int   first;
    int   sent;
    int   n;
    logic acc;
    logic prev_stall;
    logic [15:0] pf;
    logic [2:0]  pi;
    logic        pl;
    exp_t e;

    tbl[0] = '{32'h80FF7F01, {16'h8000, 16'hFF00, 16'h7F00, 16'h0100}};
    tbl[1] = '{32'h00000000, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    tbl[2] = '{32'h7F7F8080, {16'h7F00, 16'h7F00, 16'h8000, 16'h8000}};
    tbl[3] = '{32'h12345678, {16'h1200, 16'h3400, 16'h5600, 16'h7800}};
    tbl[4] = '{32'hFEDCBA98, {16'hFE00, 16'hDC00, 16'hBA00, 16'h9800}};

    // Reset state
    in_valid_a = 1'b1;
    in_word_a  = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst_out_fixed_a", 32'(out_fixed_a), 32'd0);
    chk("rst_out_idx_a", 32'(out_idx_a), 32'd0);
    chk("rst_out_last_a", 32'(out_last_a), 32'd0);
    chk("rst_in_ready_a", 32'(in_ready_a), 32'd0);
    chk("rst_in_ready_b", 32'(in_ready_b), 32'd0);
    chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_a", 32'(in_ready_a), 32'd1);
    chk("post_rst_in_ready_b", 32'(in_ready_b), 32'd1);

    // Table: one full 4-element vector per word
    for (int t = 0; t < 5; t++) begin
      accept_a(tbl[t].word);
      @(negedge clk);
      chk("tbl_latency_gap", 32'(out_valid_a), 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("tbl_valid", 32'(out_valid_a), 32'd1);
        chk("tbl_fixed", 32'(out_fixed_a), 32'(tbl[t].exp_fixed[16*k +: 16]));
        chk("tbl_idx", 32'(out_idx_a), 32'(k));
        chk("tbl_last", 32'(out_last_a), 32'(k == 3));
      end
      @(negedge clk);
      chk("tbl_drained", 32'(out_valid_a), 32'd0);
    end

    // Backpressure while 0x7F00 is presented
    accept_a(32'h80FF7F01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid_a), 32'd1);
      chk("bp_fixed", 32'(out_fixed_a), 32'h7F00);
      chk("bp_idx", 32'(out_idx_a), 32'd1);
      chk("bp_in_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("bp_rel_fixed", 32'(out_fixed_a), 32'h7F00);
    chk("bp_rel_idx", 32'(out_idx_a), 32'd1);
    @(negedge clk);
    chk("bp_next_fixed", 32'(out_fixed_a), 32'hFF00);
    chk("bp_next_in_ready", 32'(in_ready_a), 32'd1);
    @(negedge clk);
    chk("bp_tail_fixed", 32'(out_fixed_a), 32'h8000);
    chk("bp_tail_last", 32'(out_last_a), 32'd1);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid_a), 32'd0);

    // Back-to-back words on a
    got_f.delete(); got_i.delete(); got_l.delete(); got_v.delete(); got_r.delete();
    @(posedge clk); #1;
    fork
      begin
        in_word_a  = 32'h04030201;
        in_valid_a = 1'b1;
        wait_ready_a();
        @(posedge clk); #1;
        in_word_a = 32'h08070605;
        wait_ready_a();
        @(posedge clk); #1;
        in_valid_a = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          got_v.push_back(out_valid_a);
          got_f.push_back(out_fixed_a);
          got_i.push_back(3'(out_idx_a));
          got_l.push_back(out_last_a);
          got_r.push_back(in_ready_a);
        end
      end
    join
    first = -1;
    for (int c = 0; c < 16; c++) if (first < 0 && got_v[c]) first = c;
    if (first < 0 || first > 7) begin
      chk("b2b_first_valid", 32'(first), 32'd2);
    end else begin
      for (int k = 0; k < 8; k++) begin
        chk("b2b_valid", 32'(got_v[first+k]), 32'd1);
        chk("b2b_fixed", 32'(got_f[first+k]), 32'((k + 1) * 256));
        chk("b2b_idx", 32'(got_i[first+k]), 32'(k % 4));
        chk("b2b_last", 32'(got_l[first+k]), 32'((k % 4) == 3));
        if ((k % 4) == 2) chk("b2b_in_ready_lane3", 32'(got_r[first+k]), 32'd1);
        if ((k % 4) == 1) chk("b2b_in_ready_mid", 32'(got_r[first+k]), 32'd0);
      end
      chk("b2b_after", 32'(got_v[first+8]), 32'd0);
    end

    // Reset mid-vector
    accept_a(32'h44332211);
    n = 0;
    @(negedge clk);
    while (!(out_valid_a && out_idx_a == 2'd2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_saw_idx2", 32'(out_fixed_a), 32'h3300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_fixed", 32'(out_fixed_a), 32'd0);
    chk("mid_rst_idx", 32'(out_idx_a), 32'd0);
    chk("mid_rst_last", 32'(out_last_a), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
    accept_a(32'h00000055);
    @(negedge clk);
    chk("mid_new_gap", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    chk("mid_new_valid", 32'(out_valid_a), 32'd1);
    chk("mid_new_fixed", 32'(out_fixed_a), 32'h5500);
    chk("mid_new_idx", 32'(out_idx_a), 32'd0);

    // Partial last word on b (N_ELEMS=6)
    pw[0] = 32'h04030201; pw[1] = 32'h08070605; pw[2] = 32'h0A090000;
    for (int k = 0; k < 6; k++) begin
      pexp_f[k] = 16'((k + 1) * 256);
      pexp_i[k] = 3'(k);
    end
    pexp_f[6] = 16'h0000; pexp_f[7] = 16'h0000; pexp_f[8] = 16'h0900; pexp_f[9] = 16'h0A00;
    for (int k = 6; k < 10; k++) pexp_i[k] = 3'(k - 6);
    got_f.delete(); got_i.delete(); got_l.delete();
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int w = 0; w < 3; w++) begin
          in_word_b  = pw[w];
          in_valid_b = 1'b1;
          wait_ready_b();
          @(posedge clk); #1;
        end
        in_valid_b = 1'b0;
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(negedge clk);
          if (out_valid_b) begin
            got_f.push_back(out_fixed_b);
            got_i.push_back(out_idx_b);
            got_l.push_back(out_last_b);
          end
        end
      end
    join
    chk("part_count", 32'(got_f.size()), 32'd10);
    for (int k = 0; k < 10 && k < got_f.size(); k++) begin
      chk("part_fixed", 32'(got_f[k]), 32'(pexp_f[k]));
      chk("part_idx", 32'(got_i[k]), 32'(pexp_i[k]));
      chk("part_last", 32'(got_l[k]), 32'(k == 5));
    end

    // Randomized scoreboard on b
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid_b = 1'b0;
    mq.delete();
    mpos       = 0;
    sent       = 0;
    acc        = 1'b0;
    prev_stall = 1'b0;
    pf = '0; pi = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 30000 && (sent < 1000 || mq.size() > 0 || out_valid_b); cyc++) begin
      if (acc) in_valid_b = 1'b0;
      if (!in_valid_b && sent < 1000 && $urandom_range(3) != 0) begin
        in_word_b  = $urandom;
        in_valid_b = 1'b1;
      end
      out_ready_b = ($urandom_range(2) != 0);
      @(negedge clk);
      if (prev_stall) begin
        chk("rand_stall_valid", 32'(out_valid_b), 32'd1);
        chk("rand_stall_fixed", 32'(out_fixed_b), 32'(pf));
        chk("rand_stall_idx", 32'(out_idx_b), 32'(pi));
        chk("rand_stall_last", 32'(out_last_b), 32'(pl));
      end
      acc = in_valid_b && in_ready_b;
      if (acc) begin
        model_push(in_word_b);
        sent++;
      end
      if (out_valid_b && out_ready_b) begin
        if (mq.size() == 0) begin
          chk("rand_spurious_element", 32'd1, 32'd0);
        end else begin
          e = mq.pop_front();
          chk("rand_fixed", 32'(out_fixed_b), 32'(e.f));
          chk("rand_idx", 32'(out_idx_b), 32'(e.i));
          chk("rand_last", 32'(out_last_b), 32'(e.l));
        end
      end
      prev_stall = out_valid_b && !out_ready_b;
      pf = out_fixed_b;
      pi = out_idx_b;
      pl = out_last_b;
      @(posedge clk); #1;
    end
    chk("rand_words_sent", 32'(sent), 32'd1000);
    chk("rand_drained", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
